// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: load/store initiator for one valid/ready memory port.
// Takes one byte/half/word request at a time from the memory stage and turns it into
// a word-aligned memory access with byte write enables. It waits for the memory's
// ready pulse or a timeout, then returns an extended load result or an error.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_*             core request (valid/ready, we, size, unsigned, addr, wdata)
//   resp_*            one-cycle response pulse with held err/rdata
//   mem_*             memory port (one-cycle valid pulse, ready pulse, aligned addr,
//                     lane-replicated wdata, byte enables, read data)

`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif

module lsu_mem_initiator #(
  parameter int unsigned ADDR_WIDTH     = `RISCV_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  output logic                  resp_err_o,
  output logic [31:0]           resp_rdata_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_we_o,
  input  logic [31:0]           mem_rdata_i
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  store_q;

  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [31:0]           resp_rdata_q;
  logic                  mem_valid_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic [3:0]            mem_we_q;

  // Request decode: legality, byte enables and lane-replicated store data.
  logic [1:0]  req_off;
  logic        req_bad;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_rep;

  always_comb begin
    req_off       = req_addr_i[1:0];
    req_bad       = 1'b0;
    req_be        = 4'b0000;
    req_wdata_rep = req_wdata_i;
    unique case (req_size_i)
      2'b00: begin
        req_be        = 4'b0001 << req_off;
        req_wdata_rep = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        req_bad       = req_off[0];
        req_be        = 4'b0011 << req_off;
        req_wdata_rep = {2{req_wdata_i[15:0]}};
      end
      2'b10: begin
        req_bad = (req_off != 2'b00);
        req_be  = 4'b1111;
      end
      default: req_bad = 1'b1;
    endcase
  end

  // Load extraction from the live memory word, using the latched request shape.
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  always_comb begin
    rd_shift = mem_rdata_i >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   rd_ext = uns_q ? {24'b0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = uns_q ? {16'b0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      store_q      <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 4'b0000;
    end else begin
      // Pulsed outputs default low; everything else holds.
      mem_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            off_q       <= req_off;
            size_q      <= req_size_i;
            uns_q       <= req_unsigned_i;
            store_q     <= req_we_i;
            req_ready_q <= 1'b0;
            if (req_bad) begin
              // Reject without touching memory.
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q     <= StIssue;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata_q <= req_wdata_rep;
              mem_we_q    <= req_we_i ? req_be : 4'b0000;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        StIssue: begin
          state_q <= StWait;
          cnt_q   <= CntWidth'(TIMEOUT_CYCLES);
        end
        StWait: begin
          if (mem_ready_i) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= store_q ? 32'h0 : rd_ext;
          end else if (cnt_q == CntWidth'(1)) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign mem_valid_o  = mem_valid_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_we_o     = mem_we_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
module tb_lsu_mem_initiator;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;

  lsu_mem_initiator #(
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_size_i    (req_size),
    .req_unsigned_i(req_unsigned),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .resp_valid_o  (resp_valid),
    .resp_err_o    (resp_err),
    .resp_rdata_o  (resp_rdata),
    .mem_valid_o   (mem_valid),
    .mem_ready_i   (mem_ready),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_we_o      (mem_we),
    .mem_rdata_i   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Cycle numbering: cycle c spans from the c-th rising edge to the next.
  int cyc = 0;
  int rst_edge_cyc = -1;  // last cycle whose opening edge sampled rst_n low

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) rst_edge_cyc <= cyc + 1;
  end

  // Transaction-level expectations, written by the driver at accept time.
  int          acc_cyc = -100;
  int          busy_lo = 0;
  int          busy_hi = -1;
  int          mv_cyc = -1;
  int          resp_cyc = -1;
  int          mem_lo = 0;
  int          mem_hi = -1;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_we;
  logic        resp_err_e;
  logic [31:0] resp_rdata_e;

  logic [7:0]  byte_mem [64];

  // Observations of the DUT, used by the literal checks.
  int          obs_mv_cnt;
  int          obs_mv_cyc = -1;
  int          obs_mv_cyc_prev = -1;
  int          obs_rel;
  logic        obs_err;
  logic [31:0] obs_rdata;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    int   c;
    logic live;
    logic held_err;
    logic [31:0] held_rdata;
    held_err   = 1'b0;
    held_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_edge_cyc >= 0) begin
        c    = cyc;
        live = (acc_cyc > rst_edge_cyc);
        if (c == rst_edge_cyc) begin
          held_err   = 1'b0;
          held_rdata = '0;
          chk("rst_req_ready", 32'(req_ready), 32'd0);
          chk("rst_resp_valid", 32'(resp_valid), 32'd0);
          chk("rst_resp_err", 32'(resp_err), 32'd0);
          chk("rst_resp_rdata", resp_rdata, 32'd0);
          chk("rst_mem_valid", 32'(mem_valid), 32'd0);
          chk("rst_mem_addr", mem_addr, 32'd0);
          chk("rst_mem_wdata", mem_wdata, 32'd0);
          chk("rst_mem_we", 32'(mem_we), 32'd0);
        end else begin
          if (c == acc_cyc) begin
            obs_mv_cnt = 0;
            obs_rel    = -1;
            obs_err    = 1'bx;
            obs_rdata  = 32'hDEAD_BEEF;
          end
          if (live && c == resp_cyc) begin
            held_err   = resp_err_e;
            held_rdata = resp_rdata_e;
          end
          chk("req_ready", 32'(req_ready), 32'(!(live && c >= busy_lo && c <= busy_hi)));
          chk("mem_valid", 32'(mem_valid), 32'(live && c == mv_cyc));
          chk("resp_valid", 32'(resp_valid), 32'(live && c == resp_cyc));
          chk("resp_err", 32'(resp_err), 32'(held_err));
          chk("resp_rdata", resp_rdata, held_rdata);
          if (live && c >= mem_lo && c <= mem_hi) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            if (exp_we != 4'b0000) chk("mem_wdata", mem_wdata, exp_wdata);
          end
          if (mem_valid === 1'b1) begin
            obs_mv_cnt++;
            obs_mv_cyc_prev = obs_mv_cyc;
            obs_mv_cyc      = c;
            obs_addr        = mem_addr;
            obs_wdata       = mem_wdata;
            obs_we          = mem_we;
          end
          if (resp_valid === 1'b1) begin
            obs_rel   = c - acc_cyc;
            obs_err   = resp_err;
            obs_rdata = resp_rdata;
          end
        end
      end
    end
  end

  // One transaction, entered #1 after the edge that opens an idle cycle.
  // lat: cycles after ISSUE until the memory answers (0 = never answers).
  // noise: 0 none, 1 stray ready in ISSUE, 2 stray ready in RESP.
  // rst_k: cycle offset from accept at which rst_n is driven low (-1 = never).
  task automatic do_txn(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int lat,
                        input bit hold, input int noise, input int rst_k);
    int          t, rc, rdy, nz, tail, ai, wbi, offi, nb;
    logic        bad;
    logic [7:0]  b0, b1;
    logic [31:0] word;
    t    = cyc;
    ai   = int'(addr[5:0]);
    wbi  = ai & ~3;
    offi = int'(addr[1:0]);
    nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    bad  = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
    if (bad) begin
      rc  = t + 1;
      rdy = -1;
    end else if (lat == 0) begin
      rc  = t + 2 + TO;
      rdy = -1;
    end else begin
      rc  = t + 2 + lat;
      rdy = t + 1 + lat;
    end
    word = {byte_mem[wbi+3], byte_mem[wbi+2], byte_mem[wbi+1], byte_mem[wbi]};
    b0   = byte_mem[ai];
    b1   = (sz == 2'b01) ? byte_mem[ai+1] : 8'h00;

    exp_addr = {addr[31:2], 2'b00};
    exp_we   = 4'b0000;
    for (int i = 0; i < 4; i++) if (we && i >= offi && i < offi + nb) exp_we[i] = 1'b1;
    exp_wdata = (sz == 2'b00) ? {4{wd[7:0]}} : (sz == 2'b01) ? {2{wd[15:0]}} : wd;
    if (bad || lat == 0) begin
      resp_err_e   = 1'b1;
      resp_rdata_e = '0;
    end else begin
      resp_err_e = 1'b0;
      if (we)              resp_rdata_e = '0;
      else if (sz == 2'b00) resp_rdata_e = uns ? {24'h0, b0} : {{24{b0[7]}}, b0};
      else if (sz == 2'b01) resp_rdata_e = uns ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      else                 resp_rdata_e = word;
    end
    busy_lo  = t + 1;
    busy_hi  = rc;
    resp_cyc = rc;
    mv_cyc   = bad ? -1 : t + 1;
    mem_lo   = t + 1;
    mem_hi   = bad ? -1 : rc - 1;
    acc_cyc  = t;

    nz   = (noise == 1 && !bad) ? t + 1 : (noise == 2) ? rc : -1;
    tail = (!bad && lat == 0) ? 2 : (hold ? 0 : $urandom_range(0, 1));

    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    for (int c = t; c <= rc + tail; c++) begin
      req_valid = (c == t) || (hold && c <= rc);
      mem_ready = (c == rdy) || (c == nz) || (!bad && lat == 0 && c == rc + 2);
      mem_rdata = (c == rdy) ? word : $urandom();
      if (c == rdy && we) for (int i = 0; i < nb; i++) byte_mem[ai+i] = wd[8*i +: 8];
      if (rst_k >= 0 && c == t + rst_k) rst_n = 1'b0;
      @(posedge clk);
      #1;
      if (rst_k >= 0 && c == t + rst_k) begin
        rst_n     = 1'b1;
        req_valid = 1'b0;
        mem_ready = 1'b1;  // a late completion during reset must be ignored
        mem_rdata = $urandom();
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        return;
      end
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    int          r;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    mem_ready    = 1'b0;
    mem_rdata    = '0;
    for (int i = 0; i < 64; i++) byte_mem[i] = 8'($urandom());
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Byte store then unsigned byte load.
    do_txn(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00A5, 1, 1'b0, 0, -1);
    chk("st_b_we", 32'(obs_we), 32'h8);
    chk("st_b_addr", obs_addr, 32'h10);
    chk("st_b_wdata", obs_wdata, 32'hA5A5_A5A5);
    do_txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1, 1'b0, 0, -1);
    chk("ld_bu_rdata", obs_rdata, 32'h0000_00A5);
    chk("ld_bu_lat", obs_rel, 32'd3);

    // Word store then signed/unsigned half loads from the upper half.
    do_txn(1'b1, 2'b10, 1'b0, 32'h20, 32'h8001_7FFF, 1, 1'b0, 0, -1);
    do_txn(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 2, 1'b0, 1, -1);
    chk("ld_hs_rdata", obs_rdata, 32'hFFFF_8001);
    do_txn(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1, 1'b0, 2, -1);
    chk("ld_hu_rdata", obs_rdata, 32'h0000_8001);

    // Misaligned and illegal requests.
    do_txn(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1, 1'b0, 0, -1);
    chk("mis_h_err", 32'(obs_err), 32'd1);
    chk("mis_h_lat", obs_rel, 32'd1);
    chk("mis_h_nomem", obs_mv_cnt, 32'd0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1, 1'b0, 0, -1);
    chk("mis_w_err", 32'(obs_err), 32'd1);
    chk("mis_w_nomem", obs_mv_cnt, 32'd0);
    do_txn(1'b1, 2'b11, 1'b0, 32'h20, 32'h0, 1, 1'b0, 0, -1);
    chk("ill_err", 32'(obs_err), 32'd1);
    chk("ill_nomem", obs_mv_cnt, 32'd0);

    // Timeout with a late ready two cycles after the error response.
    do_txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 1'b0, 0, -1);
    chk("to_mv_cnt", obs_mv_cnt, 32'd1);
    chk("to_lat", obs_rel, 32'd6);
    chk("to_err", 32'(obs_err), 32'd1);

    // Back-to-back with req_valid held high.
    do_txn(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1, 1'b1, 0, -1);
    do_txn(1'b1, 2'b10, 1'b0, 32'h8, 32'h1234_5678, 1, 1'b1, 0, -1);
    chk("b2b_spacing", obs_mv_cyc - obs_mv_cyc_prev, 32'd4);

    // Reset while waiting on memory.
    do_txn(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 3, 1'b0, 0, 2);
    chk("rst_release_ready", 32'(req_ready), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      addr = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) addr[0] = 1'b0;
        else if (sz == 2'b10) addr[1:0] = 2'b00;
      end
      do_txn(1'($urandom()), sz, 1'($urandom()), addr, $urandom(), $urandom_range(0, TO),
             1'($urandom()), $urandom_range(0, 2),
             ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
